fir_decim_mac_sequencer: RTL

- Control block for the single-MAC FIR decimator datapath (TAP_COUNT taps, decimation DECIM).
- Accepts input beats on an AXIS-style slave handshake and generates write addresses for the sample ring buffer.
- After every DECIM accepted beats, sequences one full TAP_COUNT-cycle MAC pass, waits for the MAC pipeline to drain, then presents one decimated output.
- Produces all sample-buffer, coefficient-ROM and MAC control strobes; holds no data itself.

---
 rtl/fir_decim_mac_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fir_decim_mac_sequencer.sv
// Control sequencer for a single-MAC FIR decimator.
// Accepts DECIM input beats per output, then runs one TAP_COUNT-cycle MAC
// pass over the sample ring buffer, waits MAC_LAT cycles for the MAC pipe
// to drain and presents the decimated result until the sink takes it.
// Ports:
//   clk, nrst               clock, synchronous active-low reset
//   s_tvalid / s_tready     input beat handshake
//   buf_wr_en, buf_wr_addr  ring-buffer write strobe and address
//   buf_rd_addr, coef_addr  per-tap sample and coefficient addresses
//   mac_en, mac_first       MAC operand valid, first tap of a pass
//   mac_zero                operand precedes stream start, use 0
//   m_tvalid / m_tready     decimated result handshake
//   out_count               results handed off, wraps at 2^16
module fir_decim_mac_sequencer #(
    parameter int unsigned TAP_COUNT = 121,
    parameter int unsigned DECIM     = 8,
    parameter int unsigned BUF_DEPTH = 128,
    parameter int unsigned MAC_LAT   = 3,
    parameter int unsigned AW        = $clog2(BUF_DEPTH),
    parameter int unsigned CW        = $clog2(TAP_COUNT)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          s_tvalid,
    output logic          s_tready,
    output logic          buf_wr_en,
    output logic [AW-1:0] buf_wr_addr,
    output logic [AW-1:0] buf_rd_addr,
    output logic [CW-1:0] coef_addr,
    output logic          mac_en,
    output logic          mac_first,
    output logic          mac_zero,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [15:0]   out_count
);

    localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned FW = $clog2(TAP_COUNT + 1);
    localparam int unsigned DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_MAC    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] newest_q, newest_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [CW-1:0] k_q, k_d;
    logic [DW-1:0] drain_q, drain_d;
    logic [15:0]   out_count_q, out_count_d;
    logic          mac_en_q, mac_en_d;
    logic          mac_first_q, mac_first_d;
    logic          mac_zero_q, mac_zero_d;
    logic          m_tvalid_q, m_tvalid_d;
    logic [AW-1:0] buf_rd_addr_q, buf_rd_addr_d;
    logic [CW-1:0] coef_addr_q, coef_addr_d;

    // Handshake decode straight from the state register
    assign s_tready    = (state_q == ST_ACCEPT);
    assign buf_wr_en   = s_tvalid & s_tready;
    assign buf_wr_addr = wr_ptr_q;

    assign buf_rd_addr = buf_rd_addr_q;
    assign coef_addr   = coef_addr_q;
    assign mac_en      = mac_en_q;
    assign mac_first   = mac_first_q;
    assign mac_zero    = mac_zero_q;
    assign m_tvalid    = m_tvalid_q;
    assign out_count   = out_count_q;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        newest_d    = newest_q;
        phase_d     = phase_q;
        fill_d      = fill_q;
        k_d         = k_q;
        drain_d     = drain_q;
        out_count_d = out_count_q;

        case (state_q)
            ST_ACCEPT: begin
                if (buf_wr_en) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (fill_q != FW'(TAP_COUNT)) begin
                        fill_d = fill_q + FW'(1);
                    end
                    if (phase_q == PW'(DECIM - 1)) begin
                        phase_d  = '0;
                        newest_d = wr_ptr_q;
                        k_d      = '0;
                        state_d  = ST_MAC;
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
            end
            ST_MAC: begin
                if (k_q == CW'(TAP_COUNT - 1)) begin
                    drain_d = '0;
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == DW'(MAC_LAT - 1)) begin
                    state_d = ST_OUT;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            ST_OUT: begin
                if (m_tvalid_q && m_tready) begin
                    out_count_d = out_count_q + 16'd1;
                    state_d     = ST_ACCEPT;
                end
            end
            default: state_d = ST_ACCEPT;
        endcase

        // Strobes are registered versions of the decode of the next state
        mac_en_d      = (state_d == ST_MAC);
        mac_first_d   = mac_en_d && (k_d == '0);
        mac_zero_d    = mac_en_d && (32'(k_d) >= 32'(fill_d));
        m_tvalid_d    = (state_d == ST_OUT);
        coef_addr_d   = mac_en_d ? k_d : coef_addr_q;
        // Modular AW-bit subtraction walks back through the ring buffer
        buf_rd_addr_d = mac_en_d ? (newest_d - AW'(k_d)) : buf_rd_addr_q;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q       <= ST_ACCEPT;
            wr_ptr_q      <= '0;
            newest_q      <= '0;
            phase_q       <= '0;
            fill_q        <= '0;
            k_q           <= '0;
            drain_q       <= '0;
            out_count_q   <= '0;
            mac_en_q      <= 1'b0;
            mac_first_q   <= 1'b0;
            mac_zero_q    <= 1'b0;
            m_tvalid_q    <= 1'b0;
            buf_rd_addr_q <= '0;
            coef_addr_q   <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            newest_q      <= newest_d;
            phase_q       <= phase_d;
            fill_q        <= fill_d;
            k_q           <= k_d;
            drain_q       <= drain_d;
            out_count_q   <= out_count_d;
            mac_en_q      <= mac_en_d;
            mac_first_q   <= mac_first_d;
            mac_zero_q    <= mac_zero_d;
            m_tvalid_q    <= m_tvalid_d;
            buf_rd_addr_q <= buf_rd_addr_d;
            coef_addr_q   <= coef_addr_d;
        end
    end

endmodule
